// File: rtl/fsm_moore_pkg.sv
// Shared definitions for the 1101 Moore pattern detector.
package fsm_moore_pkg;

  localparam int unsigned STATE_W = 3;

  // Codes 3'b101..3'b111 are unused and always recover to S0.
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'b000,  // idle, no prefix seen
    S1 = 3'b001,  // seen "1"
    S2 = 3'b010,  // seen "11"
    S3 = 3'b011,  // seen "110"
    S4 = 3'b100   // seen "1101", detected
  } state_t;

endpackage

// File: rtl/fsm_moore_detector.sv
// Moore FSM detecting overlapping occurrences of 1101 on a serial input.
// Y is decoded from the state register alone, one cycle after the final '1'.
module fsm_moore_detector
  import fsm_moore_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic Din,
  output logic Y
);

  state_t state;
  state_t w_next_state;

  // State register with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S0;
    end else begin
      state <= w_next_state;
    end
  end

  // Next-state logic; illegal codes fall back to S0.
  always_comb begin
    w_next_state = S0;
    case (state)
      S0: w_next_state = Din ? S1 : S0;
      S1: w_next_state = Din ? S2 : S0;
      S2: w_next_state = Din ? S2 : S3;
      S3: w_next_state = Din ? S4 : S0;
      // Trailing '1' of the pattern plus a new '1' re-enters "11".
      S4: w_next_state = Din ? S2 : S0;
      default: w_next_state = S0;
    endcase
  end

  // Output decode from state only.
  always_comb begin
    Y = (state == S4);
  end

endmodule

// File: tb/tb_fsm_moore_detector.sv
// Scoreboard bench for fsm_moore_detector: stimulus pushes the expected
// {state, Y} after each edge; a monitor pops and compares after each edge.
module tb_fsm_moore_detector;

  logic Clock;
  logic Reset;
  logic Din;
  logic Y;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [3:0] exp_q [$];

  fsm_moore_detector dut (
    .Clock (Clock),
    .Reset (Reset),
    .Din   (Din),
    .Y     (Y)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [2:0] cur_state();
    return 3'(dut.state);
  endfunction

  task automatic check(input string name, input logic [2:0] es, input logic ey);
    logic [2:0] as;
    as = cur_state();
    n_checks++;
    if (as !== es || Y !== ey) begin
      n_errors++;
      $display("FAIL %s: state=%b Y=%b, expected state=%b Y=%b", name, as, Y, es, ey);
    end
  endtask

  // Drive one bit at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic din, input logic [2:0] es);
    @(negedge Clock);
    Din = din;
    exp_q.push_back({es, (es == 3'd4)});
  endtask

  // Monitor: compare the DUT against the oldest expectation just after each rising edge.
  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb", e[3:1], e[0]);
      end
    end
  end

  initial begin : stim
    int unsigned wait_cycles;
    Din   = 1'b0;
    Reset = 1'b0;
    #1;
    check("reset_async", 3'd0, 1'b0);

    // Reset held with Din toggling.
    step(1'b1, 3'd0);
    step(1'b0, 3'd0);
    step(1'b1, 3'd0);

    // Release at a falling edge; the next rising edge is the first sample.
    @(negedge Clock);
    Reset = 1'b1;
    Din   = 1'b1;
    exp_q.push_back({3'd1, 1'b0});
    // Basic detect: 1,0,1,1,0,1 (first 1 driven above).
    step(1'b0, 3'd0);
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    step(1'b0, 3'd3);
    step(1'b1, 3'd4);
    step(1'b0, 3'd0);

    // Overlap: 1,1,0,1,1,0,1 gives two detections.
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    step(1'b0, 3'd3);
    step(1'b1, 3'd4);
    step(1'b1, 3'd2);
    step(1'b0, 3'd3);
    step(1'b1, 3'd4);
    step(1'b0, 3'd0);

    // Near-misses: 1,1,1,0,0,1,1,0,0 never reaches S4.
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    step(1'b1, 3'd2);
    step(1'b0, 3'd3);
    step(1'b0, 3'd0);
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    step(1'b0, 3'd3);
    step(1'b0, 3'd0);

    // Mid-pattern reset: 1,1,0 then async pulse while in S3, then 1.
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    step(1'b0, 3'd3);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("reset_in_s3", 3'd0, 1'b0);
    #1;
    Reset = 1'b1;
    Din   = 1'b1;
    exp_q.push_back({3'd1, 1'b0});

    // Reach S4 and clear it asynchronously.
    step(1'b1, 3'd2);
    step(1'b0, 3'd3);
    step(1'b1, 3'd4);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("reset_in_s4", 3'd0, 1'b0);
    #1;
    Reset = 1'b1;
    Din   = 1'b0;
    exp_q.push_back({3'd0, 1'b0});

    // Illegal code 3'b111 with Din=1, then 3'b101 with Din=0.
    @(negedge Clock);
    force dut.state = fsm_moore_pkg::state_t'(3'b111);
    #1;
    check("illegal_111_y", 3'b111, 1'b0);
    release dut.state;
    Din = 1'b1;
    exp_q.push_back({3'd0, 1'b0});
    @(negedge Clock);
    force dut.state = fsm_moore_pkg::state_t'(3'b101);
    #1;
    check("illegal_101_y", 3'b101, 1'b0);
    release dut.state;
    Din = 1'b0;
    exp_q.push_back({3'd0, 1'b0});

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge Clock);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
